// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Purpose  : Shared state encoding and default timing constants for the
//            digital-lock sequencing controller and its idle timer.
// Revision : 1.0  initial release
// ============================================================================
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } lock_state_t;

  localparam int c_default_n              = 4;
  localparam int c_default_digits         = 4;
  localparam int c_default_timeout        = 15;
  localparam int c_default_max_fail       = 3;
  localparam int c_default_open_cycles    = 20;
  localparam int c_default_lockout_cycles = 50;

endpackage
`default_nettype wire

// File: rtl/lock_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : lock_idle_timer
// Purpose  : Counts consecutive qualifying idle cycles and flags expiry on the
//            TIMEOUT-th one.
// Ports    : clock   in  1  posedge clock
//            reset   in  1  synchronous active-high reset
//            enable  in  1  counting allowed (controller is collecting digits)
//            clear   in  1  restart the count (a key is down)
//            expired out 1  high for the cycle that completes TIMEOUT idle
//                           cycles; the count restarts after it
// Revision : 1.0  initial release
// ============================================================================
module lock_idle_timer
  import lock_pkg::*;
#(
  parameter int TIMEOUT = c_default_timeout
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_cnt;
  logic          w_count;

  assign w_count = enable && !clear;
  // Expiry is flagged in the same cycle as the final idle cycle so the
  // controller reacts on the edge that completes exactly TIMEOUT idle cycles.
  assign expired = w_count && (r_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset || !w_count || expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : lock_controller
// Purpose  : Digital-lock sequencer. Detects key presses, collects a
//            DIGITS-long entry, abandons it after an idle timeout, compares it
//            against `code` and drives unlock / error / lockout indications.
//            Optional feature macro: LOCK_LOCKOUT_EN (fail counter + LOCKOUT).
// Ports    : clock       in  1                  posedge clock
//            reset       in  1                  synchronous active-high reset
//            key         in  N                  button levels, 1 = pressed
//            code        in  DIGITS*W           passcode, digit i at [i*W +: W]
//            unlocked    out 1                  high while OPEN
//            alarm       out 1                  high while LOCKOUT
//            error       out 1                  one-cycle pulse on mismatch
//            timeout     out 1                  one-cycle pulse on idle abandon
//            digit_count out $clog2(DIGITS+1)   digits captured so far
// Revision : 1.0  initial release
// ============================================================================
module lock_controller
  import lock_pkg::*;
#(
  parameter int N              = c_default_n,
  parameter int DIGITS         = c_default_digits,
  parameter int TIMEOUT        = c_default_timeout,
  parameter int MAX_FAIL       = c_default_max_fail,
  parameter int OPEN_CYCLES    = c_default_open_cycles,
  parameter int LOCKOUT_CYCLES = c_default_lockout_cycles
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N-1:0]                   key,
  input  logic [DIGITS*$clog2(N)-1:0]    code,
  output logic                           unlocked,
  output logic                           alarm,
  output logic                           error,
  output logic                           timeout,
  output logic [$clog2(DIGITS+1)-1:0]    digit_count
);

  localparam int W        = $clog2(N);
  localparam int CW       = $clog2(DIGITS + 1);
  // One hold counter serves both OPEN and LOCKOUT.
  localparam int HOLD_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  if (N < 2 || DIGITS < 1 || TIMEOUT < 1 || MAX_FAIL < 1 ||
      OPEN_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_config
    $error("lock_controller: unsupported parameter set");
  end

  lock_state_t           r_state, w_state_nxt;
  logic [N-1:0]          r_key_prev;
  logic [DIGITS*W-1:0]   r_entry, w_entry_nxt;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic [HW-1:0]         r_hold, w_hold_nxt;
  logic                  r_unlocked, r_error, r_timeout;
  logic                  w_error_nxt, w_timeout_nxt;
  logic                  w_press, w_expired, w_timer_en, w_timer_clr;
  logic [W-1:0]          w_digit;

`ifdef LOCK_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic [FW-1:0]         r_fail, w_fail_nxt;
  logic                  r_alarm;
`endif

  // A press is the first cycle any key is down after a cycle with none down;
  // holding or adding keys does not retrigger.
  assign w_press = (|key) && !(|r_key_prev);

  // Lowest set bit wins when several keys go down together.
  always_comb begin
    w_digit = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (key[i]) w_digit = W'(i);
    end
  end

  assign w_timer_en  = (r_state == ENTRY);
  assign w_timer_clr = |key;

  lock_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (w_timer_en),
    .clear   (w_timer_clr),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_entry_nxt   = r_entry;
    w_count_nxt   = r_count;
    w_hold_nxt    = r_hold;
    w_error_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
`ifdef LOCK_LOCKOUT_EN
    w_fail_nxt    = r_fail;
`endif
    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_entry_nxt[0 +: W] = w_digit;
          w_count_nxt         = CW'(1);
          w_state_nxt         = (DIGITS == 1) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        // A press outranks a coincident timer expiry.
        if (w_press) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_count == CW'(i)) w_entry_nxt[i*W +: W] = w_digit;
          end
          w_count_nxt = r_count + 1'b1;
          if (r_count == CW'(DIGITS - 1)) w_state_nxt = CHECK;
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_count_nxt   = '0;
          w_state_nxt   = IDLE;
        end
      end
      CHECK: begin
        w_count_nxt = '0;
        w_hold_nxt  = '0;
        if (r_entry == code) begin
          w_state_nxt = OPEN;
`ifdef LOCK_LOCKOUT_EN
          w_fail_nxt  = '0;
`endif
        end else begin
          w_error_nxt = 1'b1;
`ifdef LOCK_LOCKOUT_EN
          w_fail_nxt  = r_fail + 1'b1;
          w_state_nxt = (w_fail_nxt == FW'(MAX_FAIL)) ? LOCKOUT : IDLE;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      OPEN: begin
        if (r_hold == HW'(OPEN_CYCLES - 1)) begin
          w_hold_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_hold_nxt  = r_hold + 1'b1;
        end
      end
`ifdef LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (r_hold == HW'(LOCKOUT_CYCLES - 1)) begin
          w_hold_nxt  = '0;
          w_fail_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_hold_nxt  = r_hold + 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Status outputs follow the next state so they change on the same edge as
  // the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_key_prev <= '0;
      r_entry    <= '0;
      r_count    <= '0;
      r_hold     <= '0;
      r_unlocked <= 1'b0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_key_prev <= key;
      r_entry    <= w_entry_nxt;
      r_count    <= w_count_nxt;
      r_hold     <= w_hold_nxt;
      r_unlocked <= (w_state_nxt == OPEN);
      r_error    <= w_error_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

`ifdef LOCK_LOCKOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fail  <= '0;
      r_alarm <= 1'b0;
    end else begin
      r_fail  <= w_fail_nxt;
      r_alarm <= (w_state_nxt == LOCKOUT);
    end
  end
  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

  assign unlocked    = r_unlocked;
  assign error       = r_error;
  assign timeout     = r_timeout;
  assign digit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_controller
// Purpose  : Self-checking bench for lock_controller. Expected output events
//            (unlock windows, error/timeout pulses, alarm windows) are queued
//            as stimulus is applied and matched as the DUT produces them.
// Revision : 1.0  initial release
// ============================================================================
module tb_lock_controller;

  localparam int N              = 4;
  localparam int DIGITS         = 4;
  localparam int W              = 2;
  localparam int CW             = 3;
  localparam int TIMEOUT        = 15;
  localparam int MAX_FAIL       = 3;
  localparam int OPEN_CYCLES    = 20;
  localparam int LOCKOUT_CYCLES = 50;

  localparam logic [DIGITS*W-1:0] C_OK  = {2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [DIGITS*W-1:0] C_BAD = {2'd3, 2'd3, 2'd3, 2'd3};
  localparam logic [DIGITS*W-1:0] C_MK  = {2'd3, 2'd2, 2'd1, 2'd1};

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [N-1:0]         key   = '0;
  logic [DIGITS*W-1:0]  code  = C_OK;
  logic                 unlocked, alarm, error, timeout;
  logic [CW-1:0]        digit_count;

  typedef struct {
    byte kind;
    int  cyc;
    int  len;
  } ev_t;

  ev_t exp_q[$];
  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  k, k2, k3;
  bit  u_prev  = 1'b0;
  bit  a_prev  = 1'b0;
  int  u_start = 0;
  int  a_start = 0;

  always #5 clock = ~clock;

  lock_controller #(
    .N              (N),
    .DIGITS         (DIGITS),
    .TIMEOUT        (TIMEOUT),
    .MAX_FAIL       (MAX_FAIL),
    .OPEN_CYCLES    (OPEN_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .code        (code),
    .unlocked    (unlocked),
    .alarm       (alarm),
    .error       (error),
    .timeout     (timeout),
    .digit_count (digit_count)
  );

  task automatic expect_ev(input byte kind, input int c, input int len);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Scoreboard: each event the DUT produces is matched against the oldest
  // expectation.
  task automatic sb_match(input byte kind, input int c, input int len);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got %c at cycle %0d len %0d, required no event", kind, c, len);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.cyc !== c || e.len !== len)
        begin
          n_fail++;
          $display("FAIL sb_event: got %c at cycle %0d len %0d, required %c at cycle %0d len %0d",
                   kind, c, len, e.kind, e.cyc, e.len);
        end
    end
  endtask

  // Advance n cycles; outputs are observed at the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cyc++;
      if (error === 1'b1)   sb_match("E", cyc, 1);
      if (timeout === 1'b1) sb_match("T", cyc, 1);
      if (unlocked === 1'b1 && !u_prev) begin
        u_prev  = 1'b1;
        u_start = cyc;
      end else if (unlocked !== 1'b1 && u_prev) begin
        u_prev = 1'b0;
        sb_match("U", u_start, cyc - u_start);
      end
      if (alarm === 1'b1 && !a_prev) begin
        a_prev  = 1'b1;
        a_start = cyc;
      end else if (alarm !== 1'b1 && a_prev) begin
        a_prev = 1'b0;
        sb_match("A", a_start, cyc - a_start);
      end
    end
  endtask

  // Press digits first..DIGITS-1 of val, 2 cycles held, 2 cycles gap; the
  // outcome of the final press is queued before its edge arrives.
  task automatic enter(input logic [DIGITS*W-1:0] val, input int first, input bit ok,
                       input int ulen, input bit alrm, output int kl);
    kl = 0;
    for (int i = first; i < DIGITS; i++) begin
      key = N'(1) << val[i*W +: W];
      kl  = cyc + 1;
      if (i == DIGITS - 1) begin
        if (ok) expect_ev("U", kl + 1, ulen);
        else    expect_ev("E", kl + 1, 1);
        if (alrm) expect_ev("A", kl + 1, LOCKOUT_CYCLES);
      end
      step(2);
      key = '0;
      step(2);
    end
  endtask

  task automatic test_end(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d events outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    n_tests++; if (unlocked !== 1'b0) begin n_fail++; $display("FAIL reset_unlocked: got %b, required 0", unlocked); end
    n_tests++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %b, required 0", alarm); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b, required 0", error); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
    n_tests++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", digit_count); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_unlock();
    code = C_OK;
    key  = 4'b0001;
    step(2);
    n_tests++; if (digit_count !== 3'd1) begin n_fail++; $display("FAIL unlock_count1: got %0d, required 1", digit_count); end
    key = '0;
    step(2);
    enter(C_OK, 1, 1'b1, OPEN_CYCLES, 1'b0, k);
    n_tests++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL unlock_open: got %b, required 1", unlocked); end
    key = 4'b0100;
    step(2);
    key = '0;
    n_tests++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL unlock_open_press: got %0d, required 0", digit_count); end
    step(OPEN_CYCLES);
    n_tests++; if (unlocked !== 1'b0) begin n_fail++; $display("FAIL unlock_closed: got %b, required 0", unlocked); end
    test_end("unlock");
  endtask

  task automatic test_multikey();
    code = C_MK;
    key  = 4'b0110;
    step(10);
    key  = '0;
    n_tests++; if (digit_count !== 3'd1) begin n_fail++; $display("FAIL multikey_count: got %0d, required 1", digit_count); end
    step(2);
    enter(C_MK, 1, 1'b1, OPEN_CYCLES, 1'b0, k);
    step(OPEN_CYCLES);
    test_end("multikey");
  endtask

  task automatic test_timeout();
    key = 4'b0010;
    k   = cyc + 1;
    step(2);
    key = '0;
    n_tests++; if (digit_count !== 3'd1) begin n_fail++; $display("FAIL timeout_count1: got %0d, required 1", digit_count); end
    expect_ev("T", k + 2 + TIMEOUT - 1, 1);
    step(TIMEOUT);
    n_tests++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL timeout_cleared: got %0d, required 0", digit_count); end
    // 14 idle cycles, then a press on the cycle that would have expired.
    key = 4'b0100;
    k2  = cyc + 1;
    step(2);
    key = '0;
    step(TIMEOUT - 1);
    n_tests++; if (digit_count !== 3'd1) begin n_fail++; $display("FAIL timeout_14idle: got %0d, required 1", digit_count); end
    key = 4'b1000;
    k3  = cyc + 1;
    step(2);
    key = '0;
    n_tests++; if (digit_count !== 3'd2) begin n_fail++; $display("FAIL timeout_press_wins: got %0d, required 2 (k2=%0d k3=%0d)", digit_count, k2, k3); end
    expect_ev("T", k3 + 2 + TIMEOUT - 1, 1);
    step(TIMEOUT);
    n_tests++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL timeout_cleared2: got %0d, required 0", digit_count); end
    step(2);
    test_end("timeout");
  endtask

  task automatic test_wrong_then_right();
    code = C_OK;
    for (int r = 0; r < 2; r++) begin
      enter(C_BAD, 0, 1'b0, 0, 1'b0, k);
      enter(C_BAD, 0, 1'b0, 0, 1'b0, k);
      enter(C_OK, 0, 1'b1, OPEN_CYCLES, 1'b0, k);
      step(OPEN_CYCLES);
    end
    n_tests++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL wrong_right_alarm: got %b, required 0", alarm); end
    test_end("wrong_right");
  endtask

  task automatic test_lockout();
    code = C_OK;
    enter(C_BAD, 0, 1'b0, 0, 1'b0, k);
    enter(C_BAD, 0, 1'b0, 0, 1'b0, k);
`ifdef LOCK_LOCKOUT_EN
    enter(C_BAD, 0, 1'b0, 0, 1'b1, k);
    key = 4'b0001;
    step(2);
    key = '0;
    step(2);
    n_tests++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL lockout_alarm: got %b, required 1", alarm); end
    n_tests++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL lockout_ignore: got %0d, required 0", digit_count); end
    // Press first sampled on the edge that leaves LOCKOUT, then held.
    step((k + LOCKOUT_CYCLES) - cyc);
    key = 4'b0001;
    step(4);
    key = '0;
    n_tests++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL lockout_end: got %b, required 0", alarm); end
    n_tests++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL lockout_exit_press: got %0d, required 0", digit_count); end
    step(2);
    enter(C_BAD, 0, 1'b0, 0, 1'b0, k);
    enter(C_BAD, 0, 1'b0, 0, 1'b0, k);
    enter(C_OK, 0, 1'b1, OPEN_CYCLES, 1'b0, k);
    step(OPEN_CYCLES);
`else
    enter(C_BAD, 0, 1'b0, 0, 1'b0, k);
    step(5);
    n_tests++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL lockout_disabled_alarm: got %b, required 0", alarm); end
    n_tests++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL lockout_disabled_count: got %0d, required 0", digit_count); end
`endif
    test_end("lockout");
  endtask

  task automatic test_reset_open();
    code = C_OK;
    enter(C_OK, 0, 1'b1, 5, 1'b0, k);
    key = 4'b0010;
    step(1);
    key = '0;
    step(1);
    n_tests++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL rstopen_open: got %b, required 1", unlocked); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_tests++; if (unlocked !== 1'b0) begin n_fail++; $display("FAIL rstopen_unlocked: got %b, required 0", unlocked); end
    n_tests++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL rstopen_count: got %0d, required 0", digit_count); end
    key = 4'b0001;
    step(2);
    key = '0;
    n_tests++; if (digit_count !== 3'd1) begin n_fail++; $display("FAIL rstopen_idle_press: got %0d, required 1", digit_count); end
    step(2);
    enter(C_OK, 1, 1'b1, OPEN_CYCLES, 1'b0, k);
    step(OPEN_CYCLES);
    test_end("reset_open");
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_multikey();
    test_timeout();
    test_wrong_then_right();
    test_lockout();
    test_reset_open();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
